// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// controller states and small decode helpers used by the FSM.
package dmem_ctrl_pkg;

   // Access size as presented on req_size; SIZE_RSVD behaves as a word access
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2,
      SIZE_RSVD = 2'd3
   } size_e;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      CAP  = 2'd2,
      WR   = 2'd3
   } state_e;

   // Word and reserved sizes both move a full 32-bit word
   function automatic logic is_word_size(input logic [1:0] size);
      return size[1];
   endfunction

   // Halves need addr[0]=0, words need addr[1:0]=0, reserved size is never legal
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_HALF: bad = offset[0];
         SIZE_WORD: bad = (offset != 2'b00);
         SIZE_RSVD: bad = 1'b1;
         default:   bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Lane steering for the data-memory controller. Pure combinational:
// extracts and sign/zero-extends the addressed lane of a loaded word, and
// builds the read-modify-write word for sub-word stores. Lanes are
// little-endian; byte lanes select on offset[1:0], half lanes on offset[1].
module dmem_lane_unit
   import dmem_ctrl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [15:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Pick the addressed byte and half out of the memory word
   always_comb begin
      byte_lane = word[{offset, 3'b000} +: 8];
      half_lane = word[{offset[1], 4'b0000} +: 16];
   end

   // Load result: extend the selected lane, or pass the whole word through
   always_comb begin
      load_data = word;
      case (size)
         SIZE_BYTE: load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
         SIZE_HALF: load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
         default:   load_data = word;
      endcase
   end

   // Store merge: overwrite only the addressed lane of the old word
   always_comb begin
      merge_data = word;
      case (size)
         SIZE_BYTE: merge_data[{offset, 3'b000} +: 8]     = wdata[7:0];
         SIZE_HALF: merge_data[{offset[1], 4'b0000} +: 16] = wdata;
         default:   merge_data = word;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a 32-bit word-organised
// data memory with a 1-cycle registered read port and a separate write port.
// One request is outstanding at a time. Sub-word stores are done as an
// atomic read-modify-write (RD -> CAP -> WR); word stores write directly.
// Optional build macro DMEM_MISALIGN_TRAP_EN adds rsp_err and turns
// misaligned or reserved-size requests into an immediate error response
// with no memory access; without it the low address bits are ignored.
module dmem_access_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
`ifdef DMEM_MISALIGN_TRAP_EN
   output logic                  rsp_err,
`endif
   output logic [ADDR_WIDTH-1:0] mem_read_addr,
   output logic [ADDR_WIDTH-1:0] mem_write_addr,
   output logic [31:0]           mem_data,
   output logic                  mem_we,
   input  logic [31:0]           mem_q
);

   state_e                state;
   logic [ADDR_WIDTH+1:0] addr_q;
   size_e                 size_q;
   logic                  signed_q;
   logic                  we_q;
   logic [31:0]           wdata_q;
   logic [31:0]           merge_q;

   logic [31:0]           load_data;
   logic [31:0]           merge_data;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  accept;

   // Address bits above the word index select nothing in this memory
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

   // Handshake and memory-side drive derived from state and latched request
   always_comb begin
      req_ready      = (state == IDLE);
      accept         = req_valid && req_ready;
      word_idx       = addr_q[ADDR_WIDTH+1:2];
      mem_read_addr  = word_idx;
      mem_write_addr = word_idx;
      mem_we         = (state == WR);
      mem_data       = is_word_size(size_q) ? wdata_q : merge_q;
   end

   dmem_lane_unit u_lane (
      .word       (mem_q),
      .offset     (addr_q[1:0]),
      .size       (size_q),
      .sign_ext   (signed_q),
      .wdata      (wdata_q[15:0]),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // Request sequencing FSM with registered response outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         size_q    <= SIZE_BYTE;
         signed_q  <= 1'b0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         merge_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
         rsp_err   <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
         rsp_err   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q   <= req_addr[ADDR_WIDTH+1:0];
                  size_q   <= size_e'(req_size);
                  signed_q <= req_signed;
                  we_q     <= req_we;
                  wdata_q  <= req_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
                  // Illegal requests answer next cycle and never touch memory
                  if (is_misaligned(req_size, req_addr[1:0])) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else
`endif
                  if (req_we && is_word_size(req_size)) begin
                     state <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               state <= CAP;
            end
            CAP: begin
               if (!we_q) begin
                  rsp_rdata <= load_data;
                  rsp_valid <= 1'b1;
                  state     <= IDLE;
               end else begin
                  merge_q <= merge_data;
                  state   <= WR;
               end
            end
            WR: begin
               rsp_valid <= 1'b1;
               rsp_rdata <= '0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
